uart_tx_framer: RTL and testbench
=================================

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 SHALL have port: clk  input  1  transmit bit clock; one serial bit per rising edge.
REQ-002 SHALL have port: rst  input  1  reset; synchronous to clk, active-high.
REQ-003 SHALL have port: P_DATA  input  8  byte to transmit; sampled only on acceptance.
REQ-004 SHALL have port: data_valid  input  1  request to send P_DATA.
REQ-005 SHALL have port: PAR_EN  input  1  1 = insert parity bit; sampled on acceptance.
REQ-006 SHALL have port: parity_bit  input  1  parity of the accepted byte, from the upstream parity stage (that stage latches on data_valid && !busy).
REQ-007 SHALL have port: TX_OUT  output  1  serial line; idle high.
REQ-008 SHALL have port: busy  output  1  frame in progress; gates upstream latching.
REQ-009 SHALL have port: tx_done  output  1  one-cycle pulse at end of frame.
REQ-010 SHALL register all outputs (no combinational path from any input to any output).

Function
REQ-011 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP (plus STOP2 per REQ-024).
REQ-012 Acceptance SHALL occur at a rising edge where state = IDLE and data_valid = 1: latch P_DATA and PAR_EN, go to START.
REQ-013 data_valid while state != IDLE SHALL be ignored; no queuing, no corruption of the frame in flight.
REQ-014 Output timing after acceptance edge E0: TX_OUT = 0 after E0; busy = 1 after E0.
REQ-015 DATA: after E1..E8 TX_OUT = latched byte bits 0..7, LSB first; 3-bit counter, DATA exits when counter = 7.
REQ-016 PARITY (latched PAR_EN = 1 only): after E9 TX_OUT = parity_bit as sampled at E9.
REQ-017 STOP: TX_OUT = 1 for one cycle; after the STOP cycle the FSM enters IDLE with busy = 0 and tx_done = 1 for exactly one cycle.
REQ-018 Frame length (busy-high cycles): 11 with parity, 10 without.
REQ-019 IDLE SHALL last at least one cycle between frames so the upstream stage sees busy = 0 at the next acceptance.
REQ-020 In IDLE: TX_OUT = 1, busy = 0; tx_done = 0 except the single cycle in REQ-017.
REQ-021 Changes to P_DATA or PAR_EN mid-frame SHALL NOT affect the frame in flight.

Reset
REQ-022 rst = 1 at any rising edge SHALL force IDLE, TX_OUT = 1, busy = 0, tx_done = 0, bit counter = 0, data register = 8'h00; rst overrides data_valid.
REQ-023 Reset mid-frame SHALL abort the frame immediately, with no tx_done pulse; the first post-reset acceptance is at the first edge with rst = 0 and data_valid = 1.

Configuration
REQ-024 Macro UART_TX_STOP2_EN defined: STOP is followed by STOP2 (TX_OUT = 1, one more cycle); frame length is 12 with parity, 11 without; tx_done fires after STOP2.
REQ-025 UART_TX_STOP2_EN undefined: STOP2 state and logic are absent; single stop bit per REQ-017.

Verification
REQ-026 Reset: assert rst for 2 cycles mid-DATA -> next cycle TX_OUT = 1, busy = 0, tx_done = 0; no tx_done follows.
REQ-027 P_DATA = 8'hA5, PAR_EN = 1, parity_bit = 0 -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1; busy high for 11 cycles; single tx_done.
REQ-028 P_DATA = 8'h3C, PAR_EN = 0 -> TX_OUT sequence 0,0,0,1,1,1,1,0,0,1; busy high for 10 cycles.
REQ-029 data_valid held high continuously with 8'h01 then 8'hFF -> two frames separated by at least 1 IDLE cycle; second frame carries 8'hFF; P_DATA changes mid-frame are ignored.
REQ-030 P_DATA = 8'h00 with parity_bit = 1 (odd type) -> TX_OUT parity slot = 1.
REQ-031 With UART_TX_STOP2_EN defined, 8'hA5 with parity -> 12 busy cycles ending in two 1s; tx_done after the second stop bit.

Source files
------------

// File: rtl/uart_tx_framer.sv
// ----------------------------------------------------------------------------
// uart_tx_framer
//
// Serialises one byte per frame onto a UART line, one bit per clk edge:
//   start(0), data bits 0..7 (LSB first), optional parity, stop(1)
//   [, second stop(1) when UART_TX_STOP2_EN is defined].
// A frame is accepted on an edge where the FSM is idle and data_valid = 1.
// Requests arriving while a frame is in flight are dropped.
//
// Configuration macro:
//   UART_TX_STOP2_EN - append a second stop bit to every frame.
//
// Ports:
//   clk        in   bit clock, one serial bit per rising edge
//   rst        in   synchronous active-high reset
//   P_DATA     in   byte to send, latched on acceptance
//   data_valid in   send request
//   PAR_EN     in   insert parity bit, latched on acceptance
//   parity_bit in   parity value from upstream, sampled when leaving DATA
//   TX_OUT     out  serial line, idles high (registered)
//   busy       out  frame in progress (registered)
//   tx_done    out  one-cycle pulse once the frame has finished (registered)
// ----------------------------------------------------------------------------
module uart_tx_framer (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] P_DATA,
    input  logic       data_valid,
    input  logic       PAR_EN,
    input  logic       parity_bit,
    output logic       TX_OUT,
    output logic       busy,
    output logic       tx_done
);

`ifdef UART_TX_STOP2_EN
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StStop2
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;
`endif

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] data_q, data_d;
    logic       par_en_q, par_en_d;
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    // Outputs are computed one state ahead so they can be driven from flops:
    // the value in tx_d is what the line shows in the state being entered.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        par_en_d = par_en_q;
        tx_d     = 1'b1;
        busy_d   = 1'b1;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (data_valid) begin
                    data_d   = P_DATA;
                    par_en_d = PAR_EN;
                    state_d  = StStart;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            StStart: begin
                state_d = StData;
                cnt_d   = 3'd0;
                tx_d    = data_q[0];
            end
            StData: begin
                if (cnt_q == 3'd7) begin
                    cnt_d = 3'd0;
                    if (par_en_q) begin
                        state_d = StParity;
                        tx_d    = parity_bit;
                    end else begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    tx_d  = data_q[cnt_q + 3'd1];
                end
            end
            StParity: begin
                state_d = StStop;
            end
`ifdef UART_TX_STOP2_EN
            StStop: begin
                state_d = StStop2;
            end
            StStop2: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
`else
            StStop: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
`endif
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= 3'd0;
            data_q   <= 8'h00;
            par_en_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            par_en_q <= par_en_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign TX_OUT  = tx_q;
    assign busy    = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_framer
//
// Self-checking bench for uart_tx_framer. A frame-level reference model
// (a queue of pending line symbols per accepted byte) is compared against the
// DUT every cycle; a table of known frames and a few hand-written sequences
// check exact bit patterns, reset abort and back-to-back requests.
// ----------------------------------------------------------------------------
module tb_uart_tx_framer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       PAR_EN;
    logic       parity_bit;
    logic       TX_OUT;
    logic       busy;
    logic       tx_done;

    int checks = 0;
    int errors = 0;

    uart_tx_framer dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .PAR_EN     (PAR_EN),
        .parity_bit (parity_bit),
        .TX_OUT     (TX_OUT),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

`ifdef UART_TX_STOP2_EN
    localparam int NStop = 2;
`else
    localparam int NStop = 1;
`endif

    // Reference model: symbols still to appear on the line after future edges.
    // 0/1 = literal bit, 2 = parity_bit sampled at that edge, 3 = frame end.
    int   m_q[$];
    logic m_tx   = 1'b1;
    logic m_busy = 1'b0;
    logic m_done = 1'b0;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0b expected=%0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic dv, input logic [7:0] d,
                              input logic pe, input logic pb);
        int it;
        if (r) begin
            m_q.delete();
            m_tx = 1'b1; m_busy = 1'b0; m_done = 1'b0;
        end else if (m_q.size() > 0) begin
            it = m_q.pop_front();
            if (it == 3) begin
                m_tx = 1'b1; m_busy = 1'b0; m_done = 1'b1;
            end else begin
                m_tx   = (it == 2) ? pb : (it == 1);
                m_busy = 1'b1;
                m_done = 1'b0;
            end
        end else if (dv) begin
            m_tx = 1'b0; m_busy = 1'b1; m_done = 1'b0;
            for (int k = 0; k < 8; k++) m_q.push_back(int'(d[k]));
            if (pe) m_q.push_back(2);
            for (int k = 0; k < NStop; k++) m_q.push_back(1);
            m_q.push_back(3);
        end else begin
            m_tx = 1'b1; m_busy = 1'b0; m_done = 1'b0;
        end
    endtask

    // One clock: drive inputs, advance the model, sample #1 after the edge.
    task automatic tick(input logic r, input logic dv, input logic [7:0] d,
                        input logic pe, input logic pb);
        rst = r; data_valid = dv; P_DATA = d; PAR_EN = pe; parity_bit = pb;
        model_edge(r, dv, d, pe, pb);
        @(posedge clk);
        #1;
        chk("model_tx", TX_OUT, m_tx);
        chk("model_busy", busy, m_busy);
        chk("model_done", tx_done, m_done);
        @(negedge clk);
    endtask

    typedef struct {
        string      name;
        logic [7:0] data;
        logic       pe;
        logic       pb;
        int         len;      // busy cycles with a single stop bit
        bit         seq[11];  // TX_OUT after acceptance edge and following edges
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input vec_t v);
        tick(1'b0, 1'b1, v.data, v.pe, v.pb);
        chk({v.name, "_start"}, TX_OUT, v.seq[0]);
        chk({v.name, "_busy0"}, busy, 1'b1);
        for (int i = 1; i < v.len; i++) begin
            // Mid-frame input changes must not leak into the frame.
            tick(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom), v.pb);
            chk({v.name, "_bit"}, TX_OUT, v.seq[i]);
            chk({v.name, "_busy"}, busy, 1'b1);
            chk({v.name, "_nodone"}, tx_done, 1'b0);
        end
        for (int i = 1; i < NStop; i++) begin
            tick(1'b0, 1'b0, 8'h00, 1'b0, v.pb);
            chk({v.name, "_stop2"}, TX_OUT, 1'b1);
            chk({v.name, "_stop2_busy"}, busy, 1'b1);
        end
        tick(1'b0, 1'b0, 8'h00, 1'b0, v.pb);
        chk({v.name, "_end_busy"}, busy, 1'b0);
        chk({v.name, "_end_done"}, tx_done, 1'b1);
        chk({v.name, "_end_tx"}, TX_OUT, 1'b1);
        tick(1'b0, 1'b0, 8'h00, 1'b0, v.pb);
        chk({v.name, "_done_once"}, tx_done, 1'b0);
    endtask

    bit   tx_log[40];
    bit   busy_log[40];

    initial begin
        int   gap;
        int   st;
        logic [7:0] got;

        vecs[0] = '{name: "a5_p0", data: 8'hA5, pe: 1'b1, pb: 1'b0, len: 11,
                    seq: '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1}};
        vecs[1] = '{name: "3c_np", data: 8'h3C, pe: 1'b0, pb: 1'b0, len: 10,
                    seq: '{0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 0}};
        vecs[2] = '{name: "00_p1", data: 8'h00, pe: 1'b1, pb: 1'b1, len: 11,
                    seq: '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1}};
        vecs[3] = '{name: "81_np", data: 8'h81, pe: 1'b0, pb: 1'b1, len: 10,
                    seq: '{0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0}};
        vecs[4] = '{name: "a5_p1", data: 8'hA5, pe: 1'b1, pb: 1'b1, len: 11,
                    seq: '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1}};

        rst = 1'b1; data_valid = 1'b0; P_DATA = 8'h00; PAR_EN = 1'b0; parity_bit = 1'b0;
        @(negedge clk);

        // Reset state, with data_valid asserted to show rst wins.
        tick(1'b1, 1'b1, 8'hFF, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 8'hFF, 1'b1, 1'b1);
        chk("rst_tx", TX_OUT, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", tx_done, 1'b0);
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset mid-DATA aborts the frame without a done pulse.
        tick(1'b0, 1'b1, 8'hA5, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 8'hA5, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 8'hA5, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 8'hA5, 1'b1, 1'b0);
        chk("abort_tx", TX_OUT, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", tx_done, 1'b0);
        for (int i = 0; i < 14; i++) begin
            tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            chk("abort_no_done", tx_done, 1'b0);
        end

        // data_valid held high: 8'h01 accepted, then 8'hFF for the next frame.
        tick(1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
            tx_log[i]   = TX_OUT;
            busy_log[i] = busy;
        end
        gap = -1;
        st  = -1;
        for (int i = 0; i < 40; i++) begin
            if (gap < 0 && !busy_log[i]) gap = i;
            if (gap >= 0 && st < 0 && busy_log[i]) st = i;
        end
        chk("b2b_idle_gap", 1'(gap >= 0), 1'b1);
        chk("b2b_second_frame", 1'(st >= 0 && st + 8 < 40), 1'b1);
        if (st >= 0 && st + 8 < 40) begin
            chk("b2b_start_bit", tx_log[st], 1'b0);
            for (int k = 0; k < 8; k++) got[k] = tx_log[st + 1 + k];
            checks++;
            if (got !== 8'hFF) begin
                errors++;
                $display("FAIL b2b_byte actual=%h expected=ff", got);
            end
        end
        for (int i = 0; i < 15; i++) tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Randomised traffic against the model.
        for (int n = 0; n < 600; n++) begin
            tick(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 2) == 0),
                 8'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
